freq_sweep_ctrl: RTL and testbench

Parametrised successor to the single-step frequency-search loop around the SWIPT driver. It runs an autonomous two-phase sweep: a coarse sweep of [F_MIN, F_MAX], then a fine sweep around the coarse peak. At each point it waits a settle period, averages 2^AVG_LOG2 ADC samples, and tracks the peak. It drives freq_out directly into SwiptOut, removing the ad-hoc newFreq/bestFreq muxing at toplevel.

---
 rtl/freq_sweep_ctrl_if.sv | 26 ++
 rtl/freq_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/freq_sweep_ctrl_if.sv
// Sweep controller bus: link status, start request and ADC samples in; frequency and peak result out.
`timescale 1ns/1ps
interface freq_sweep_ctrl_if #(
  parameter int unsigned FREQ_W = 20,
  parameter int unsigned ADC_W  = 12
);
  logic              swipt_alive;
  logic              start;
  logic [ADC_W-1:0]  adc;
  logic [FREQ_W-1:0] freq_out;
  logic [FREQ_W-1:0] best_freq;
  logic [ADC_W-1:0]  best_amp;
  logic              busy;
  logic              done;
  logic              fine_phase;

  modport master (
    output swipt_alive, start, adc,
    input  freq_out, best_freq, best_amp, busy, done, fine_phase
  );

  modport slave (
    input  swipt_alive, start, adc,
    output freq_out, best_freq, best_amp, busy, done, fine_phase
  );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Two-phase (coarse then fine) frequency sweep that settles, averages ADC samples
// at each point and tracks the peak; drives the SWIPT output frequency directly.
`timescale 1ns/1ps
module freq_sweep_ctrl #(
  parameter int unsigned FREQ_W     = 20,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned F_DEFAULT  = 40000,
  parameter int unsigned F_MIN      = 30000,
  parameter int unsigned F_MAX      = 50000,
  parameter int unsigned F_STEP     = 1000,
  parameter int unsigned FINE_SHIFT = 3,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned AVG_LOG2   = 3
) (
  input logic             clk,
  input logic             nrst,
  freq_sweep_ctrl_if.slave sw
);
  localparam int unsigned NSAMP     = 1 << AVG_LOG2;
  localparam int unsigned ACC_W     = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_MAX   = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int unsigned FINE_STEP = F_STEP >> FINE_SHIFT;
  localparam int unsigned XW        = FREQ_W + 1;

  typedef enum logic [2:0] {IDLE, SETTLE, ACQ, EVAL, NEXT, DONE} state_e;

  state_e              state_q, state_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [FREQ_W-1:0]   hi_q, hi_d;
  logic [FREQ_W-1:0]   step_q, step_d;
  logic [FREQ_W-1:0]   best_freq_q, best_freq_d;
  logic [ADC_W-1:0]    best_amp_q, best_amp_d;
  logic [FREQ_W-1:0]   shd_freq_q, shd_freq_d;
  logic [ADC_W-1:0]    shd_amp_q, shd_amp_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fine_q, fine_d;
  logic                first_q, first_d;

  logic [ADC_W-1:0]    avg;
  logic [XW-1:0]       nxt;
  logic [XW-1:0]       hi_cand;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      freq_q      <= FREQ_W'(F_DEFAULT);
      hi_q        <= FREQ_W'(F_MAX);
      step_q      <= FREQ_W'(F_STEP);
      best_freq_q <= FREQ_W'(F_DEFAULT);
      best_amp_q  <= '0;
      shd_freq_q  <= FREQ_W'(F_DEFAULT);
      shd_amp_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fine_q      <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      hi_q        <= hi_d;
      step_q      <= step_d;
      best_freq_q <= best_freq_d;
      best_amp_q  <= best_amp_d;
      shd_freq_q  <= shd_freq_d;
      shd_amp_q   <= shd_amp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fine_q      <= fine_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    hi_d        = hi_q;
    step_d      = step_q;
    best_freq_d = best_freq_q;
    best_amp_d  = best_amp_q;
    shd_freq_d  = shd_freq_q;
    shd_amp_d   = shd_amp_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fine_d      = fine_q;
    first_d     = first_q;

    avg     = ADC_W'(acc_q >> AVG_LOG2);
    nxt     = XW'(freq_q) + XW'(step_q);
    hi_cand = XW'(best_freq_q) + XW'(F_STEP);

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && !sw.swipt_alive) begin
          state_d = IDLE;
          freq_d  = FREQ_W'(F_DEFAULT);
          done_d  = 1'b0;
        end else if (sw.start && sw.swipt_alive) begin
          state_d     = SETTLE;
          freq_d      = FREQ_W'(F_MIN);
          hi_d        = FREQ_W'(F_MAX);
          step_d      = FREQ_W'(F_STEP);
          best_freq_d = FREQ_W'(F_DEFAULT);
          best_amp_d  = '0;
          acc_d       = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fine_d      = 1'b0;
          first_d     = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = ACQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACQ: begin
        acc_d = acc_q + ACC_W'(sw.adc);
        if (cnt_q == CNT_W'(NSAMP - 1)) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EVAL: begin
        // Strict compare keeps the earliest point on ties.
        if (first_q || (avg > best_amp_q)) begin
          best_freq_d = freq_q;
          best_amp_d  = avg;
        end
        first_d = 1'b0;
        state_d = NEXT;
      end
      NEXT: begin
        acc_d = '0;
        cnt_d = '0;
        if (nxt <= XW'(hi_q)) begin
          freq_d  = FREQ_W'(nxt);
          state_d = SETTLE;
        end else if (!fine_q) begin
          // Fine window around the coarse peak, clamped to the sweep range without underflow.
          freq_d  = (XW'(best_freq_q) >= XW'(F_MIN + F_STEP)) ?
                    (best_freq_q - FREQ_W'(F_STEP)) : FREQ_W'(F_MIN);
          hi_d    = (hi_cand <= XW'(F_MAX)) ? FREQ_W'(hi_cand) : FREQ_W'(F_MAX);
          step_d  = FREQ_W'(FINE_STEP);
          fine_d  = 1'b1;
          state_d = SETTLE;
        end else begin
          freq_d     = best_freq_q;
          shd_freq_d = best_freq_q;
          shd_amp_d  = best_amp_q;
          busy_d     = 1'b0;
          fine_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Link loss mid-sweep discards partial results and restores the last completed sweep.
    if ((state_q inside {SETTLE, ACQ, EVAL, NEXT}) && !sw.swipt_alive) begin
      state_d     = IDLE;
      freq_d      = FREQ_W'(F_DEFAULT);
      best_freq_d = shd_freq_q;
      best_amp_d  = shd_amp_q;
      acc_d       = '0;
      cnt_d       = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      fine_d      = 1'b0;
      first_d     = 1'b0;
    end
  end

  assign sw.freq_out   = freq_q;
  assign sw.best_freq  = best_freq_q;
  assign sw.best_amp   = best_amp_q;
  assign sw.busy       = busy_q;
  assign sw.done       = done_q;
  assign sw.fine_phase = fine_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: a point-by-point sweep model predicts visited frequencies and the peak.
`timescale 1ns/1ps
module tb_freq_sweep_ctrl;
  localparam int unsigned FREQ_W     = 20;
  localparam int unsigned ADC_W      = 12;
  localparam int unsigned F_DEFAULT  = 40000;
  localparam int unsigned F_MIN      = 100;
  localparam int unsigned F_MAX      = 160;
  localparam int unsigned F_STEP     = 20;
  localparam int unsigned FINE_SHIFT = 2;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned NS         = 1 << AVG_LOG2;
  localparam int unsigned P          = SETTLE_CYC + NS + 2;
  localparam int unsigned MAXP       = 64;

  logic clk = 1'b0;
  logic nrst;

  freq_sweep_ctrl_if #(.FREQ_W(FREQ_W), .ADC_W(ADC_W)) sw ();

  freq_sweep_ctrl #(
    .FREQ_W(FREQ_W), .ADC_W(ADC_W), .F_DEFAULT(F_DEFAULT), .F_MIN(F_MIN),
    .F_MAX(F_MAX), .F_STEP(F_STEP), .FINE_SHIFT(FINE_SHIFT),
    .SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .sw(sw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned pt_freq [MAXP];
  bit          pt_fine [MAXP];
  int unsigned pt_samp [MAXP][NS];
  int          n_pts;
  int unsigned exp_bf, exp_ba;
  int unsigned shadow_bf = F_DEFAULT;
  int unsigned shadow_ba = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned gen(input int mode, input int unsigned f, input int j);
    case (mode)
      1:       return (f == 140) ? 900 : ((f == 145) ? 950 : 300);
      2:       return (f == 100) ? 500 : 100;
      3:       return 700;
      4:       return (f == 120) ? ((j == 0) ? 3 : 4) : 2;
      5:       return $urandom_range(0, 4095);
      default: return $urandom_range(0, 3) * 1000;
    endcase
  endfunction

  // Whole-sweep model: one iteration per frequency point.
  task automatic run_model(input int mode);
    int unsigned f, hi, step, lo, sum, avg, bf, ba;
    bit fine, first;
    f = F_MIN; hi = F_MAX; step = F_STEP; bf = 0; ba = 0;
    fine = 0; first = 1; n_pts = 0;
    while (n_pts < MAXP) begin
      sum = 0;
      for (int j = 0; j < NS; j++) begin
        pt_samp[n_pts][j] = gen(mode, f, j);
        sum += pt_samp[n_pts][j];
      end
      avg = sum / NS;
      if (first || avg > ba) begin bf = f; ba = avg; end
      first = 0;
      pt_freq[n_pts] = f;
      pt_fine[n_pts] = fine;
      n_pts++;
      if (f + step <= hi) f += step;
      else if (!fine) begin
        lo = (bf >= F_MIN + F_STEP) ? bf - F_STEP : F_MIN;
        hi = (bf + F_STEP <= F_MAX) ? bf + F_STEP : F_MAX;
        f = lo; step = F_STEP >> FINE_SHIFT; fine = 1;
      end else break;
    end
    exp_bf = bf;
    exp_ba = ba;
  endtask

  task automatic do_sweep(input int mode, input int abort_pt, input int want_bf, input int want_ba);
    int p, k;
    run_model(mode);
    @(negedge clk);
    sw.start = 1'b1;
    sw.swipt_alive = 1'b1;
    @(posedge clk);
    for (int off = 0; off < n_pts * int'(P); off++) begin
      p = off / int'(P);
      k = off % int'(P);
      @(negedge clk);
      sw.start = (p == 1 && k == 2);
      sw.adc = (k >= int'(SETTLE_CYC) && k < int'(SETTLE_CYC + NS)) ?
               ADC_W'(pt_samp[p][k - int'(SETTLE_CYC)]) : ADC_W'($urandom);
      if (k == 1) begin
        check_eq("pt_freq", 32'(sw.freq_out), pt_freq[p]);
        check_eq("pt_fine", 32'(sw.fine_phase), 32'(pt_fine[p]));
        check_eq("pt_busy", 32'(sw.busy), 32'd1);
      end
      if (off == n_pts * int'(P) - 1) check_eq("done_early", 32'(sw.done), 32'd0);
      if (p == abort_pt && k == 3) begin
        sw.swipt_alive = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_freq", 32'(sw.freq_out), 32'(F_DEFAULT));
        check_eq("abort_busy", 32'(sw.busy), 32'd0);
        check_eq("abort_done", 32'(sw.done), 32'd0);
        check_eq("abort_fine", 32'(sw.fine_phase), 32'd0);
        check_eq("abort_bf", 32'(sw.best_freq), shadow_bf);
        check_eq("abort_ba", 32'(sw.best_amp), shadow_ba);
        sw.swipt_alive = 1'b1;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    sw.start = 1'b0;
    check_eq("done", 32'(sw.done), 32'd1);
    check_eq("done_busy", 32'(sw.busy), 32'd0);
    check_eq("done_fine", 32'(sw.fine_phase), 32'd0);
    check_eq("best_freq", 32'(sw.best_freq), exp_bf);
    check_eq("best_amp", 32'(sw.best_amp), exp_ba);
    check_eq("done_freq", 32'(sw.freq_out), exp_bf);
    if (want_bf >= 0) check_eq("want_bf", 32'(sw.best_freq), 32'(want_bf));
    if (want_ba >= 0) check_eq("want_ba", 32'(sw.best_amp), 32'(want_ba));
    shadow_bf = exp_bf;
    shadow_ba = exp_ba;
    repeat (2) @(negedge clk);
    check_eq("done_hold", 32'(sw.done), 32'd1);
    check_eq("done_hold_freq", 32'(sw.freq_out), exp_bf);
  endtask

  initial begin
    sw.start = 1'b0;
    sw.swipt_alive = 1'b0;
    sw.adc = '0;
    nrst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sw.start = 1'($urandom);
      sw.swipt_alive = 1'($urandom);
      sw.adc = ADC_W'($urandom);
    end
    check_eq("rst_freq", 32'(sw.freq_out), 32'(F_DEFAULT));
    check_eq("rst_bf", 32'(sw.best_freq), 32'(F_DEFAULT));
    check_eq("rst_ba", 32'(sw.best_amp), 32'd0);
    check_eq("rst_busy", 32'(sw.busy), 32'd0);
    check_eq("rst_done", 32'(sw.done), 32'd0);
    check_eq("rst_fine", 32'(sw.fine_phase), 32'd0);
    sw.start = 1'b0;
    sw.swipt_alive = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_freq", 32'(sw.freq_out), 32'(F_DEFAULT));
    check_eq("idle_busy", 32'(sw.busy), 32'd0);
    check_eq("idle_done", 32'(sw.done), 32'd0);

    sw.swipt_alive = 1'b0;
    sw.start = 1'b1;
    @(negedge clk);
    sw.start = 1'b0;
    @(negedge clk);
    check_eq("dead_start_busy", 32'(sw.busy), 32'd0);
    check_eq("dead_start_freq", 32'(sw.freq_out), 32'(F_DEFAULT));

    do_sweep(1, -1, 145, 950);
    do_sweep(2, -1, 100, 500);
    do_sweep(3, -1, 100, 700);
    do_sweep(4, -1, 120, 3);
    for (int r = 0; r < 4; r++) do_sweep(5 + (r % 2), -1, -1, -1);

    @(negedge clk);
    sw.swipt_alive = 1'b0;
    @(negedge clk);
    check_eq("done_dead_freq", 32'(sw.freq_out), 32'(F_DEFAULT));
    check_eq("done_dead_done", 32'(sw.done), 32'd0);
    check_eq("done_dead_bf", 32'(sw.best_freq), shadow_bf);
    check_eq("done_dead_ba", 32'(sw.best_amp), shadow_ba);
    sw.swipt_alive = 1'b1;

    do_sweep(1, -1, 145, 950);
    do_sweep(1, 6, -1, -1);

    @(negedge clk);
    sw.start = 1'b1;
    @(negedge clk);
    sw.start = 1'b0;
    repeat (SETTLE_CYC + 1) @(negedge clk);
    check_eq("acq_busy", 32'(sw.busy), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check_eq("arst_freq", 32'(sw.freq_out), 32'(F_DEFAULT));
    check_eq("arst_bf", 32'(sw.best_freq), 32'(F_DEFAULT));
    check_eq("arst_ba", 32'(sw.best_amp), 32'd0);
    check_eq("arst_busy", 32'(sw.busy), 32'd0);
    check_eq("arst_done", 32'(sw.done), 32'd0);
    check_eq("arst_fine", 32'(sw.fine_phase), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_arst_busy", 32'(sw.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
